ll_control: RTL and testbench

Sequencing controller for the lander state register file. It paces the simulation with an internal update prescaler and checks each proposed next state from the ALU before committing it. It commits by pulsing the register file's write enable, or stops writing permanently on touchdown and reports a landing or a crash. It sits between the ALU outputs and the register file's `wen`, and drives the status LEDs/display.

---
 rtl/ll_pkg.sv | 20 ++
 rtl/ll_tick.sv | 33 +++
 rtl/ll_control.sv | 92 +++++++++
 tb/tb_ll_control.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared lander types, BCD width, sign helper and default safe velocity
package ll_pkg;

  localparam int BCD_W = 16;
  localparam logic [BCD_W-1:0] SAFE_VEL_DEF = 16'h9970;

  typedef enum logic [2:0] {
    RUN,
    EVAL,
    WRITE,
    LANDED,
    CRASHED
  } ll_state_t;

  // Ten's complement BCD: a leading digit of 5..9 marks a negative value.
  function automatic logic bcd_neg(input logic [BCD_W-1:0] v);
    return (v[BCD_W-1 -: 4] >= 4'h5);
  endfunction

endpackage

// File: rtl/ll_tick.sv
// rtl/ll_tick.sv - free-running update prescaler, one-cycle tick every UPDATE_DIV cycles
module ll_tick #(
  parameter int UPDATE_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(UPDATE_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ll_control.sv
// rtl/ll_control.sv - paces lander steps, commits airborne states, latches landing or crash
module ll_control
  import ll_pkg::*;
#(
  parameter int               UPDATE_DIV = 25_000_000,
  parameter logic [BCD_W-1:0] SAFE_VEL   = SAFE_VEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] alt_n,
  input  logic [BCD_W-1:0] vel_n,
  output logic             wen,
  output logic             land,
  output logic             crash,
  output logic             busy
);

  ll_state_t state_q;
  logic      wen_q;
  logic      land_q;
  logic      crash_q;
  logic      busy_q;
  logic      tick;
  logic      touchdown;
  logic      vel_safe;

  ll_tick #(
    .UPDATE_DIV(UPDATE_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign touchdown = bcd_neg(alt_n) || (alt_n == '0);
  assign vel_safe  = !bcd_neg(vel_n) || (vel_n >= SAFE_VEL);

  // Outputs are registered alongside the state so each one mirrors its state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wen_q   <= 1'b0;
      land_q  <= 1'b0;
      crash_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            state_q <= EVAL;
            busy_q  <= 1'b1;
          end
        end
        EVAL: begin
          if (!touchdown) begin
            state_q <= WRITE;
            wen_q   <= 1'b1;
          end else if (vel_safe) begin
            state_q <= LANDED;
            busy_q  <= 1'b0;
            land_q  <= 1'b1;
          end else begin
            state_q <= CRASHED;
            busy_q  <= 1'b0;
            crash_q <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= RUN;
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        LANDED, CRASHED: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= RUN;
          wen_q   <= 1'b0;
          land_q  <= 1'b0;
          crash_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wen   = wen_q;
  assign land  = land_q;
  assign crash = crash_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ll_control.sv
// tb/tb_ll_control.sv - self-checking bench for ll_control against a cycle-index reference model
module tb_ll_control;

  localparam int          DIV = 4;
  localparam logic [15:0] SV  = 16'h9970;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alt_n = 16'h4400;
  logic [15:0] vel_n = 16'h9990;
  logic        wen, land, crash, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: k counts cycles since the last reset edge, tk is the accepted tick cycle.
  int k = 0;
  int tk = -100;
  int outcome = 0;

  always #5 clk = ~clk;

  ll_control #(
    .UPDATE_DIV(DIV),
    .SAFE_VEL  (SV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .alt_n(alt_n),
    .vel_n(vel_n),
    .wen  (wen),
    .land (land),
    .crash(crash),
    .busy (busy)
  );

  function automatic logic [3:0] exp_vec();
    logic in_step;
    in_step = (outcome == 0) && ((k == tk + 1) || (k == tk + 2));
    return {(outcome == 0) && (k == tk + 2), outcome == 1, outcome == 2, in_step};
  endfunction

  task automatic clock_edge();
    logic td;
    logic safe;
    @(posedge clk);
    if (rst) begin
      k = 0;
      tk = -100;
      outcome = 0;
    end else begin
      if (outcome == 0 && k == tk + 1) begin
        td   = (alt_n >= 16'h5000) || (alt_n == 16'h0000);
        safe = (vel_n < 16'h5000) || (vel_n >= SV);
        if (td) outcome = safe ? 1 : 2;
      end
      if (outcome == 0 && (k % DIV) == DIV - 1 && !(k == tk + 1 || k == tk + 2)) tk = k;
      k++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) clock_edge();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_bcd(input int max_msd);
    logic [15:0] v;
    v[15:12] = 4'($urandom_range(0, max_msd));
    v[11:8]  = 4'($urandom_range(0, 9));
    v[7:4]   = 4'($urandom_range(0, 9));
    v[3:0]   = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic test_reset();
    logic [3:0] e;
    int first_busy;
    first_busy = -1;
    alt_n = 16'h4400;
    vel_n = 16'h9990;
    rst = 1'b1;
    repeat (2) begin
      clock_edge();
      checks++;
      if ({wen, land, crash, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got %b exp 0000", {wen, land, crash, busy});
      end
    end
    rst = 1'b0;
    repeat (6) begin
      clock_edge();
      e = exp_vec();
      checks++;
      if ({wen, land, crash, busy} !== e) begin
        errors++;
        $display("FAIL reset_release k=%0d got %b exp %b", k, {wen, land, crash, busy}, e);
      end
      if (busy && first_busy < 0) first_busy = k;
    end
    checks++;
    if (first_busy !== 4) begin
      errors++;
      $display("FAIL reset_first_tick got busy at %0d exp 4", first_busy);
    end
  endtask

  task automatic test_normal_step();
    logic [3:0] e;
    int wens, busys;
    wens = 0;
    busys = 0;
    alt_n = 16'h4400;
    vel_n = 16'h9990;
    apply_reset(2);
    repeat (16) begin
      clock_edge();
      e = exp_vec();
      checks++;
      if ({wen, land, crash, busy} !== e) begin
        errors++;
        $display("FAIL normal_step k=%0d got %b exp %b", k, {wen, land, crash, busy}, e);
      end
      wens += int'(wen);
      busys += int'(busy);
    end
    checks++;
    if (wens !== 3 || busys !== 7) begin
      errors++;
      $display("FAIL normal_counts got wen=%0d busy=%0d exp wen=3 busy=7", wens, busys);
    end
  endtask

  task automatic test_touchdown();
    logic [15:0] alts[4] = '{16'h9990, 16'h0000, 16'h9995, 16'h9995};
    logic [15:0] vels[4] = '{16'h9980, 16'h9950, 16'h9970, 16'h9969};
    logic        lands[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  e;
    int wens;
    for (int c = 0; c < 4; c++) begin
      wens = 0;
      alt_n = alts[c];
      vel_n = vels[c];
      apply_reset(2);
      repeat (20) begin
        clock_edge();
        e = exp_vec();
        checks++;
        if ({wen, land, crash, busy} !== e) begin
          errors++;
          $display("FAIL touchdown_case%0d k=%0d got %b exp %b", c, k, {wen, land, crash, busy}, e);
        end
        wens += int'(wen);
      end
      checks++;
      if ({land, crash} !== {lands[c], ~lands[c]} || wens !== 0) begin
        errors++;
        $display("FAIL touchdown_final%0d got land=%b crash=%b wen=%0d exp land=%b crash=%b wen=0",
                 c, land, crash, wens, lands[c], ~lands[c]);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    logic [3:0] e;
    int first_wen;
    alt_n = 16'h4400;
    vel_n = 16'h9990;
    for (int target = 4; target <= 5; target++) begin
      apply_reset(2);
      while (k < target) clock_edge();
      checks++;
      if (busy !== 1'b1 || wen !== (target == 5)) begin
        errors++;
        $display("FAIL mid_pre_reset%0d got busy=%b wen=%b exp busy=1 wen=%b", target, busy, wen, target == 5);
      end
      rst = 1'b1;
      clock_edge();
      rst = 1'b0;
      checks++;
      if ({wen, land, crash, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset%0d got %b exp 0000", target, {wen, land, crash, busy});
      end
      first_wen = -1;
      repeat (8) begin
        clock_edge();
        e = exp_vec();
        checks++;
        if ({wen, land, crash, busy} !== e) begin
          errors++;
          $display("FAIL mid_after%0d k=%0d got %b exp %b", target, k, {wen, land, crash, busy}, e);
        end
        if (wen && first_wen < 0) first_wen = k;
      end
      checks++;
      if (first_wen !== 5) begin
        errors++;
        $display("FAIL mid_first_wen%0d got %0d exp 5", target, first_wen);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    apply_reset(1);
    repeat (600) begin
      if (!(k == tk + 1) && $urandom_range(0, 2) == 0) begin
        alt_n = ($urandom_range(0, 7) == 0) ? rnd_bcd(9) : rnd_bcd(4);
        vel_n = rnd_bcd(9);
      end
      rst = ($urandom_range(0, 29) == 0);
      clock_edge();
      e = exp_vec();
      checks++;
      if ({wen, land, crash, busy} !== e) begin
        errors++;
        $display("FAIL random k=%0d alt=%h vel=%h got %b exp %b", k, alt_n, vel_n, {wen, land, crash, busy}, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_step();
    test_touchdown();
    test_reset_mid_step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
